// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache port arbiter.
//   - arb_state_t : arbiter FSM state encoding
//   - DEF_*       : default parameter values
//   - GID_W       : grant index width for the default requester count
//   - gid_width() : grant index width for any requester count (min 1 bit)
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 15;

    // The watchdog must reach TIMEOUT-1 for TIMEOUT up to 255.
    localparam int WDOG_W = 8;

    // A single requester still needs a 1-bit index.
    function automatic int gid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GID_W = gid_width(DEF_NUM_REQ);

endpackage

// File: rtl/cache_port_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
// The search starts at i_ptr and wraps modulo N. The first set bit found wins.
//   i_valid  [N]  request vector
//   i_ptr    [W]  index with the highest priority this cycle (must be < N)
//   o_winner [W]  index of the winning request (0 when none)
//   o_any    [1]  at least one request is valid
module rr_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] i_valid,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_winner,
    output logic         o_any
);

    // Scan from the farthest candidate back to i_ptr.
    // The last hit is therefore the nearest one in rotation order.
    always_comb begin : pick
        logic [W:0]   w_sum;
        logic [W-1:0] w_idx;
        o_winner = '0;
        o_any    = 1'b0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (W+1)'(k);
            w_idx = (w_sum >= (W+1)'(N)) ? W'(w_sum - (W+1)'(N)) : W'(w_sum);
            if (i_valid[w_idx]) begin
                o_winner = w_idx;
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin sharing of one cache access port between
// NUM_REQ requesters. One transaction is in flight at a time. A watchdog
// aborts a transaction that the cache never completes.
//
// State | meaning
// IDLE  | offer req_ready to the round-robin winner and latch its request
// ISSUE | present the latched request on c_* until c_ready
// WAIT  | request accepted, wait for c_done or watchdog expiry
//
// Ports:
//   i_clk, i_rst                        clock, async active-high reset
//   i_req_valid/we/addr/wdata, o_req_ready   requester side (packed per index)
//   o_rsp_valid/rdata/hit/err           response, routed to the granted requester
//   o_c_valid/we/addr/wdata, i_c_ready  request to the cache controller
//   i_c_done/rdata/hit                  completion from the cache controller
//   o_busy, o_grant_id                  status
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int ADDR_W  = DEF_ADDR_W,
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int GW      = gid_width(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ-1:0]        i_req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_rdata,
    output logic                      o_rsp_hit,
    output logic                      o_rsp_err,
    output logic                      o_c_valid,
    input  logic                      i_c_ready,
    output logic                      o_c_we,
    output logic [ADDR_W-1:0]         o_c_addr,
    output logic [DATA_W-1:0]         o_c_wdata,
    input  logic                      i_c_done,
    input  logic [DATA_W-1:0]         i_c_rdata,
    input  logic                      i_c_hit,
    output logic                      o_busy,
    output logic [GW-1:0]             o_grant_id
);

    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [GW-1:0]       r_rr_ptr;
    logic [GW-1:0]       r_grant_id;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [WDOG_W-1:0]   r_wdog;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_hit;
    logic                r_rsp_err;

    logic [GW-1:0]       w_winner;
    logic                w_any;
    logic                w_offer;
    logic                w_accept;
    logic                w_enter_wait;
    logic                w_complete;
    logic                w_abort;
    logic [GW-1:0]       w_ptr_nxt;

    rr_pick #(
        .N (NUM_REQ),
        .W (GW)
    ) u_rr_pick (
        .i_valid  (i_req_valid),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Requests are not considered while reset is asserted.
    // This keeps req_ready low during reset.
    assign w_offer = (r_state == IDLE) && w_any && !i_rst;

    always_comb begin
        o_req_ready = '0;
        if (w_offer) begin
            o_req_ready = NUM_REQ'(1) << w_winner;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // When c_done coincides with the last watchdog cycle, completion wins.
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_enter_wait = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_offer) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (i_c_ready) begin
                    if (i_c_done) begin
                        w_complete  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_enter_wait = 1'b1;
                        w_state_nxt  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (i_c_done) begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_wdog == WDOG_LAST) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Priority moves to the requester just after the one served last.
    assign w_ptr_nxt = (r_grant_id == GW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wdog      <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;

            if (w_accept) begin
                r_grant_id <= w_winner;
                r_we       <= i_req_we[w_winner];
                r_addr     <= i_req_addr[int'(w_winner) * ADDR_W +: ADDR_W];
                r_wdata    <= i_req_wdata[int'(w_winner) * DATA_W +: DATA_W];
            end

            if (w_enter_wait) begin
                r_wdog <= '0;
            end else if (r_state == WAIT) begin
                r_wdog <= r_wdog + 1'b1;
            end

            if (w_complete) begin
                r_rsp_valid <= NUM_REQ'(1) << r_grant_id;
                r_rsp_rdata <= i_c_rdata;
                r_rsp_hit   <= i_c_hit;
                r_rsp_err   <= 1'b0;
                r_rr_ptr    <= w_ptr_nxt;
            end else if (w_abort) begin
                r_rsp_valid <= NUM_REQ'(1) << r_grant_id;
                r_rsp_rdata <= '0;
                r_rsp_hit   <= 1'b0;
                r_rsp_err   <= 1'b1;
                r_rr_ptr    <= w_ptr_nxt;
            end
        end
    end

    assign o_c_valid   = (r_state == ISSUE);
    assign o_c_we      = r_we;
    assign o_c_addr    = r_addr;
    assign o_c_wdata   = r_wdata;
    assign o_busy      = (r_state != IDLE);
    assign o_grant_id  = r_grant_id;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_hit   = r_rsp_hit;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Testbench for cache_port_arbiter with NUM_REQ=2 and TIMEOUT=15.
// The bench plays both the requesters and the cache controller.
// It predicts grants, latencies and responses from a round-robin
// reference model that uses a simple rotation search.
module tb_cache_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int TO = 15;
    localparam int GW = 1;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_hit;
    logic              rsp_err;
    logic              c_valid;
    logic              c_ready;
    logic              c_we;
    logic [AW-1:0]     c_addr;
    logic [DW-1:0]     c_wdata;
    logic              c_done;
    logic [DW-1:0]     c_rdata;
    logic              c_hit;
    logic              busy;
    logic [GW-1:0]     grant_id;

    cache_port_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_hit   (rsp_hit),
        .o_rsp_err   (rsp_err),
        .o_c_valid   (c_valid),
        .i_c_ready   (c_ready),
        .o_c_we      (c_we),
        .o_c_addr    (c_addr),
        .o_c_wdata   (c_wdata),
        .i_c_done    (c_done),
        .i_c_rdata   (c_rdata),
        .i_c_hit     (c_hit),
        .o_busy      (busy),
        .o_grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Requester side of the reference model.
    bit            pend   [NR];
    logic          f_we   [NR];
    logic [AW-1:0] f_addr [NR];
    logic [DW-1:0] f_wdata[NR];
    int            m_ptr;
    int            last_gid;

    function automatic int model_pick();
        for (int k = 0; k < NR; k++) begin
            if (pend[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic new_req(input int i);
        pend[i]    = 1'b1;
        f_we[i]    = 1'($urandom_range(0, 1));
        f_addr[i]  = AW'($urandom);
        f_wdata[i] = DW'($urandom);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]            = pend[i];
            req_we[i]               = f_we[i];
            req_addr[i*AW +: AW]    = f_addr[i];
            req_wdata[i*DW +: DW]   = f_wdata[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        c_ready = 1'b0;
        c_done  = 1'b0;
        c_hit   = 1'b0;
        c_rdata = '0;
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        drive_reqs();
        step();
        step();
        rst   = 1'b0;
        m_ptr = 0;
    endtask

    // Runs one complete transaction, starting in an IDLE cycle.
    //   rdel : cycles c_ready is held low after c_valid rises
    //   dj   : -1 means done arrives together with ready.
    //          Otherwise done arrives in WAIT cycle dj.
    //          dj >= TO means done never arrives, so the transaction aborts.
    task automatic do_txn(input int rdel, input int dj, input logic [DW-1:0] rd, input logic rh);
        int            w;
        int            limit;
        bit            aborted;
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        drive_reqs();
        #1;
        w = model_pick();
        n_vec++;
        if (w < 0 || req_ready !== NR'(NR'(1) << w) || busy !== 1'b0) begin
            n_err++;
            $display("FAIL grant_offer: req_ready=%b busy=%b expected winner %0d", req_ready, busy, w);
            return;
        end
        ewe = f_we[w];
        ea  = f_addr[w];
        ed  = f_wdata[w];
        step();
        // Scramble the winner's inputs so that only latched fields can match.
        pend[w]    = 1'b0;
        f_we[w]    = ~ewe;
        f_addr[w]  = ~ea;
        f_wdata[w] = ~ed;
        drive_reqs();
        #1;
        last_gid = int'(grant_id);
        n_vec++;
        if ({c_valid, c_we, c_addr, c_wdata, grant_id, req_ready} !==
            {1'b1, ewe, ea, ed, GW'(w), {NR{1'b0}}}) begin
            n_err++;
            $display("FAIL issue: c_valid=%b we=%b addr=%h wdata=%h gid=%0d ready=%b expected 1 %b %h %h %0d 0",
                     c_valid, c_we, c_addr, c_wdata, grant_id, req_ready, ewe, ea, ed, w);
        end
        for (int r = 0; r < rdel; r++) begin
            step();
            n_vec++;
            if ({c_valid, c_we, c_addr, c_wdata, rsp_valid} !== {1'b1, ewe, ea, ed, {NR{1'b0}}}) begin
                n_err++;
                $display("FAIL issue_hold: c_valid=%b we=%b addr=%h wdata=%h rsp_valid=%b expected 1 %b %h %h 0",
                         c_valid, c_we, c_addr, c_wdata, rsp_valid, ewe, ea, ed);
            end
        end
        c_ready = 1'b1;
        if (dj < 0) begin
            c_done  = 1'b1;
            c_rdata = rd;
            c_hit   = rh;
        end
        step();
        c_ready = 1'b0;
        c_done  = 1'b0;
        c_rdata = DW'($urandom);
        c_hit   = 1'($urandom_range(0, 1));
        aborted = 1'b0;
        if (dj >= 0) begin
            aborted = (dj > TO - 1);
            limit   = aborted ? TO : dj + 1;
            for (int j = 0; j < limit; j++) begin
                n_vec++;
                if ({busy, c_valid, rsp_valid} !== {1'b1, 1'b0, {NR{1'b0}}}) begin
                    n_err++;
                    $display("FAIL wait_cycle%0d: busy=%b c_valid=%b rsp_valid=%b expected 1 0 0",
                             j, busy, c_valid, rsp_valid);
                end
                if (j == dj) begin
                    c_done  = 1'b1;
                    c_rdata = rd;
                    c_hit   = rh;
                end
                step();
                c_done  = 1'b0;
                c_rdata = DW'($urandom);
                c_hit   = 1'($urandom_range(0, 1));
            end
        end
        n_vec++;
        if (rsp_valid !== NR'(NR'(1) << w) || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rsp_pulse: rsp_valid=%b busy=%b expected %b 0", rsp_valid, busy, NR'(NR'(1) << w));
        end
        n_vec++;
        if (aborted) begin
            if ({rsp_err, rsp_hit, rsp_rdata} !== {1'b1, 1'b0, {DW{1'b0}}}) begin
                n_err++;
                $display("FAIL rsp_abort: err=%b hit=%b rdata=%h expected 1 0 00", rsp_err, rsp_hit, rsp_rdata);
            end
        end else begin
            if ({rsp_err, rsp_hit, rsp_rdata} !== {1'b0, rh, rd}) begin
                n_err++;
                $display("FAIL rsp_data: err=%b hit=%b rdata=%h expected 0 %b %h", rsp_err, rsp_hit, rsp_rdata, rh, rd);
            end
        end
        m_ptr = (w + 1) % NR;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        c_ready = 1'b0;
        c_done  = 1'b0;
        c_rdata = '0;
        c_hit   = 1'b0;
        for (int i = 0; i < NR; i++) new_req(i);
        drive_reqs();
        step();
        step();
        n_vec++;
        if (req_ready !== '0) begin
            n_err++;
            $display("FAIL reset_ready: req_ready=%b expected 0", req_ready);
        end
        n_vec++;
        if ({c_valid, busy, rsp_valid, rsp_err, rsp_hit, rsp_rdata, grant_id, c_we, c_addr, c_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: c_valid=%b busy=%b rsp_valid=%b err=%b hit=%b rdata=%h gid=%0d we=%b addr=%h wdata=%h expected all 0",
                     c_valid, busy, rsp_valid, rsp_err, rsp_hit, rsp_rdata, grant_id, c_we, c_addr, c_wdata);
        end
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        drive_reqs();
        rst   = 1'b0;
        m_ptr = 0;
    endtask

    task automatic test_single_read();
        pend[0]   = 1'b1;
        f_we[0]   = 1'b0;
        f_addr[0] = 4'hB;
        f_wdata[0] = DW'($urandom);
        do_txn(0, 1, 8'h5A, 1'b1);
    endtask

    task automatic test_contention();
        int exp_seq[4] = '{0, 1, 0, 1};
        apply_reset();
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < NR; i++) if (!pend[i]) new_req(i);
            do_txn(0, $urandom_range(0, 2), DW'($urandom), 1'($urandom_range(0, 1)));
            n_vec++;
            if (last_gid != exp_seq[t]) begin
                n_err++;
                $display("FAIL contention_order%0d: grant_id=%0d expected %0d", t, last_gid, exp_seq[t]);
            end
        end
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    endtask

    task automatic test_write();
        pend[1]    = 1'b1;
        f_we[1]    = 1'b1;
        f_addr[1]  = 4'h2;
        f_wdata[1] = 8'hC3;
        do_txn(3, 0, DW'($urandom), 1'b1);
    endtask

    task automatic test_timeout();
        new_req(0);
        do_txn(0, 100, 8'h00, 1'b0);
        c_done  = 1'b1;
        c_rdata = 8'hFF;
        c_hit   = 1'b1;
        step();
        c_done = 1'b0;
        for (int j = 0; j < 3; j++) begin
            n_vec++;
            if ({rsp_valid, busy, rsp_err, rsp_hit, rsp_rdata} !== {{NR{1'b0}}, 1'b0, 1'b1, 1'b0, {DW{1'b0}}}) begin
                n_err++;
                $display("FAIL late_done%0d: rsp_valid=%b busy=%b err=%b hit=%b rdata=%h expected 0 0 1 0 00",
                         j, rsp_valid, busy, rsp_err, rsp_hit, rsp_rdata);
            end
            step();
        end
        new_req(1);
        do_txn(1, TO - 1, 8'h77, 1'b1);
    endtask

    task automatic test_back_to_back();
        new_req(0);
        do_txn(0, -1, 8'h3C, 1'b0);
        new_req(1);
        drive_reqs();
        #1;
        n_vec++;
        if ({rsp_valid, req_ready} !== {2'b01, 2'b10}) begin
            n_err++;
            $display("FAIL back_to_back: rsp_valid=%b req_ready=%b expected 01 10", rsp_valid, req_ready);
        end
        do_txn(0, -1, 8'hA5, 1'b1);
    endtask

    task automatic test_reset_mid_wait();
        new_req(0);
        do_txn(0, 0, 8'h11, 1'b0);
        new_req(1);
        drive_reqs();
        step();
        pend[1] = 1'b0;
        drive_reqs();
        c_ready = 1'b1;
        step();
        c_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, c_valid, rsp_valid, req_ready} !== {1'b0, 1'b0, {NR{1'b0}}, {NR{1'b0}}}) begin
            n_err++;
            $display("FAIL reset_wait: busy=%b c_valid=%b rsp_valid=%b ready=%b expected 0 0 0 0",
                     busy, c_valid, rsp_valid, req_ready);
        end
        step();
        rst   = 1'b0;
        m_ptr = 0;
        for (int j = 0; j < 4; j++) begin
            step();
            n_vec++;
            if ({rsp_valid, busy} !== {{NR{1'b0}}, 1'b0}) begin
                n_err++;
                $display("FAIL reset_no_rsp%0d: rsp_valid=%b busy=%b expected 0 0", j, rsp_valid, busy);
            end
        end
        new_req(0);
        drive_reqs();
        step();
        n_vec++;
        if (c_valid !== 1'b1) begin
            n_err++;
            $display("FAIL issue_before_reset: c_valid=%b expected 1", c_valid);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({c_valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_issue: c_valid=%b busy=%b expected 0 0", c_valid, busy);
        end
        step();
        rst   = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < NR; i++) new_req(i);
        do_txn(0, 0, 8'h42, 1'b1);
        n_vec++;
        if (last_gid != 0) begin
            n_err++;
            $display("FAIL ptr_after_reset: grant_id=%0d expected 0", last_gid);
        end
    endtask

    task automatic test_random();
        int sel;
        int dj;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
            end
            if (model_pick() < 0) new_req($urandom_range(0, NR - 1));
            sel = $urandom_range(0, 9);
            if (sel < 3)       dj = -1;
            else if (sel < 8)  dj = $urandom_range(0, 5);
            else if (sel == 8) dj = TO - 1;
            else               dj = TO + 3;
            do_txn($urandom_range(0, 3), dj, DW'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        c_ready   = 1'b0;
        c_done    = 1'b0;
        c_rdata   = '0;
        c_hit     = 1'b0;
        m_ptr     = 0;
        last_gid  = 0;
        for (int i = 0; i < NR; i++) begin
            pend[i]    = 1'b0;
            f_we[i]    = 1'b0;
            f_addr[i]  = '0;
            f_wdata[i] = '0;
        end
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
